mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU operands when the decoded is_div/is_mult flags reach EX.
- Runs a pipelined multiply or an iterative radix-2 restoring divide.
- Holds the pipeline with stall_o until done, then presents a registered {hi, lo} result with a one-cycle valid pulse for the HI/LO write.

---
 rtl/mdu_ctrl.sv | 150 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer with a registered {hi, lo} result.
// The multiply holds for MULT_STAGES cycles; the divide is radix-2 restoring, one quotient bit per cycle.
`default_nettype none

module mdu_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MULT_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_div,
  input  logic              start_mult,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall_o,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo
);

  localparam int CNT_MAX = (DATA_W > MULT_STAGES) ? DATA_W : MULT_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   op_a, op_b, b_mag, quo, rem;
  logic                sgn, neg_a, neg_b;

  logic [DATA_W:0]     shifted, diff;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt, q_fix, r_fix;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic                b_zero;

  assign accept = (start_div | start_mult) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_o      = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        state_nxt = start_div ? S_DIV : S_MULT;
        stall_o   = 1'b1;
      end
      S_MULT: begin
        stall_o = 1'b1;
        if (cnt == MULT_LAST) state_nxt = S_DONE;
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (cnt == DIV_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt    = S_IDLE;
      stall_o      = 1'b0;
      result_valid = 1'b0;
    end
    // Keep outputs quiet while reset is held, even if EX still presents a start.
    if (!rst) begin
      stall_o      = 1'b0;
      result_valid = 1'b0;
    end
  end

  // One restoring-divide step: quo shifts the dividend out as the quotient shifts in.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, b_mag};
    rem_nxt = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], ~diff[DATA_W]};
    q_fix   = (neg_a ^ neg_b) ? -quo_nxt : quo_nxt;
    r_fix   = neg_a ? -rem_nxt : rem_nxt;
    b_zero  = (b_mag == '0);
  end

  always_comb begin
    ext_a = {{DATA_W{sgn & op_a[DATA_W-1]}}, op_a};
    ext_b = {{DATA_W{sgn & op_b[DATA_W-1]}}, op_b};
    prod  = ext_a * ext_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      b_mag     <= '0;
      quo       <= '0;
      rem       <= '0;
      sgn       <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_a  <= src_a;
          op_b  <= src_b;
          sgn   <= signed_op;
          neg_a <= signed_op & src_a[DATA_W-1];
          neg_b <= signed_op & src_b[DATA_W-1];
          quo   <= (signed_op & src_a[DATA_W-1]) ? -src_a : src_a;
          b_mag <= (signed_op & src_b[DATA_W-1]) ? -src_b : src_b;
          rem   <= '0;
          cnt   <= '0;
        end
        S_MULT: begin
          cnt <= cnt + 1'b1;
          if (state_nxt == S_DONE) begin
            result_hi <= prod[2*DATA_W-1:DATA_W];
            result_lo <= prod[DATA_W-1:0];
          end
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (state_nxt == S_DONE) begin
            // Divide by zero bypasses sign correction: quotient all ones, remainder = dividend.
            result_lo <= b_zero ? '1   : q_fix;
            result_hi <= b_zero ? op_a : r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; expected {hi, lo} queued at stimulus, checked on result_valid.
`default_nettype none

module tb_mdu_ctrl;

  localparam int DATA_W      = 32;
  localparam int MULT_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_div = 1'b0, start_mult = 1'b0, signed_op = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] src_a = '0, src_b = '0;
  logic              stall_o, result_valid;
  logic [DATA_W-1:0] result_hi, result_lo;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  logic [63:0] last_res = '0;

  mdu_ctrl #(.DATA_W(DATA_W), .MULT_STAGES(MULT_STAGES)) dut (
    .clk(clk), .rst(rst), .start_div(start_div), .start_mult(start_mult),
    .signed_op(signed_op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall_o(stall_o), .result_valid(result_valid),
    .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit div, input bit sg,
                                        input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb_, sp;
    longint unsigned up;
    int              q, r;
    if (!div) begin
      if (sg) begin
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        sp = sa * sb_;
        return sp;
      end
      up = longint'(a) * longint'(b);
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Result monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("res_hi", result_hi, e[63:32]);
        chk("res_lo", result_lo, e[31:0]);
      end
    end
  end

  task automatic run_op(input bit div, input bit sg, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [63:0] e;
    lat        = div ? DATA_W : MULT_STAGES;
    e          = model(div, sg, a, b);
    start_div  = div;
    start_mult = !div;
    signed_op  = sg;
    src_a      = a;
    src_b      = b;
    sb.push_back(e);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk(div ? "div_stall" : "mult_stall", stall_o, 1);
      if (i > 0) chk("early_valid", result_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_stall", stall_o, 0);
    chk("done_valid", result_valid, 1);
    @(posedge clk); #1;
    start_div  = 1'b0;
    start_mult = 1'b0;
    last_res   = e;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", {result_hi, result_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", last_res, 64'hFFFF_FFFE_0000_0001);
    run_op(0, 1, 32'hFFFF_FFFD, 32'd7);
    run_op(0, 1, 32'd5, 32'd6);
    run_op(1, 1, 32'hFFFF_FFF9, 32'd2);
    run_op(1, 0, 32'd7, 32'd2);
    run_op(1, 0, 32'd5, 32'd0);
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1, 1, 32'hFFFF_FFF9, 32'd0);
    run_op(1, 1, 32'd100, 32'hFFFF_FFF9);
    for (int k = 0; k < 6; k++) begin
      run_op(k[0], k[1], $urandom, (k == 4) ? 32'd3 : $urandom);
    end

    // Flush at T+10 of a divide, then restart at T+11.
    start_div = 1'b1; signed_op = 1'b0; src_a = 32'd1000; src_b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("pre_flush_stall", stall_o, 1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", stall_o, 0);
    chk("flush_valid", result_valid, 0);
    chk("flush_hold", {result_hi, result_lo}, last_res);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op(1, 0, 32'd1000, 32'd7);

    // Reset pulled low at T+5 of a divide, released at T+7.
    start_div = 1'b1; signed_op = 1'b1; src_a = 32'hFFFF_0000; src_b = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("pre_rst_stall", stall_o, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_stall", stall_o, 0);
      chk("midrst_valid", result_valid, 0);
      chk("midrst_result", {result_hi, result_lo}, 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start_div = 1'b0;
    repeat (45) @(posedge clk);
    @(negedge clk);
    chk("post_rst_stall", stall_o, 0);
    chk("post_rst_result", {result_hi, result_lo}, 64'd0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
